// File: rtl/conv_window_buffer_pkg.sv
// Shared constants and packing helper for the sliding-window buffer and the
// convolution kernel, so both sides agree on the window slot layout.
package conv_window_buffer_pkg;

   // Fixed-point word: sign + integer + Q fraction bits.
   localparam int unsigned N_DEFAULT            = 25;
   localparam int unsigned Q_DEFAULT            = 14;
   localparam int unsigned FILTERHEIGHT_DEFAULT = 3;
   localparam int unsigned FILTERWIDTH_DEFAULT  = 3;

   // Slot index of window element (r, c); r=0 is the top row, c=0 the left column.
   function automatic int unsigned slot_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned fw);
      return r * fw + c;
   endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out bundle between a pixel source, the window buffer and
// the kernel. The buffer takes the slave side.
interface conv_window_buffer_if
   import conv_window_buffer_pkg::*;
#(
   parameter int unsigned N            = N_DEFAULT,
   parameter int unsigned FILTERHEIGHT = FILTERHEIGHT_DEFAULT,
   parameter int unsigned FILTERWIDTH  = FILTERWIDTH_DEFAULT
);

   logic [N-1:0]                            pixel_in;
   logic                                    pixel_valid;
   logic [N*FILTERHEIGHT*FILTERWIDTH-1:0]   window_out;
   logic                                    window_valid;
   logic                                    frame_done;

   // Pixel source / window consumer.
   modport master (
      output pixel_in,
      output pixel_valid,
      input  window_out,
      input  window_valid,
      input  frame_done
   );

   // Window buffer.
   modport slave (
      input  pixel_in,
      input  pixel_valid,
      output window_out,
      output window_valid,
      output frame_done
   );

endinterface

// File: rtl/conv_window_buffer_line_delay.sv
// One image line of delay: an IMGWIDTH-deep circular buffer that advances only
// on enable. The output is the word written DEPTH enables ago, read before the
// slot is overwritten so it lines up with the incoming pixel's column.
module conv_window_buffer_line_delay #(
   parameter int unsigned N     = 25,
   parameter int unsigned DEPTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] ptr_q;

   assign dout = mem[ptr_q];

   // Storage: contents are never cleared; the top-level counters gate validity.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr_q] <= din;
      end
   end

   // Circular write/read pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (en) begin
         if (ptr_q == AW'(DEPTH - 1)) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= ptr_q + AW'(1);
         end
      end
   end

endmodule

// File: rtl/conv_window_buffer.sv
// Sliding-window generator: buffers FILTERHEIGHT-1 lines of a raster pixel
// stream and presents every complete FILTERHEIGHT x FILTERWIDTH neighbourhood
// (valid-mode, no padding) as a packed vector for the convolution kernel.
module conv_window_buffer
   import conv_window_buffer_pkg::*;
#(
   parameter int unsigned N            = N_DEFAULT,
   parameter int unsigned FILTERHEIGHT = FILTERHEIGHT_DEFAULT,
   parameter int unsigned FILTERWIDTH  = FILTERWIDTH_DEFAULT,
   parameter int unsigned IMGWIDTH     = 32,
   parameter int unsigned IMGHEIGHT    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   conv_window_buffer_if.slave   bus
);

   localparam int unsigned CW = (IMGWIDTH > 1) ? $clog2(IMGWIDTH) : 1;
   localparam int unsigned RW = (IMGHEIGHT > 1) ? $clog2(IMGHEIGHT) : 1;
   localparam int unsigned WW = N * FILTERHEIGHT * FILTERWIDTH;

   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic          last_col;
   logic          last_row;
   logic          win_complete;

   logic [N-1:0]  tap [FILTERHEIGHT];
   logic [N-1:0]  win_q [FILTERHEIGHT][FILTERWIDTH];
   logic [WW-1:0] window_flat;
   logic          window_valid_q;
   logic          frame_done_q;

   assign last_col     = (col_q == CW'(IMGWIDTH - 1));
   assign last_row     = (row_q == RW'(IMGHEIGHT - 1));
   // Checked against the position of the pixel being accepted, so a window
   // that would straddle a line wrap is never flagged.
   assign win_complete = (row_q >= RW'(FILTERHEIGHT - 1)) && (col_q >= CW'(FILTERWIDTH - 1));

   // Tap 0 is the live pixel; tap k is the same column k lines earlier.
   assign tap[0] = bus.pixel_in;

   for (genvar k = 1; k < FILTERHEIGHT; k++) begin : g_line
      conv_window_buffer_line_delay #(
         .N     (N),
         .DEPTH (IMGWIDTH)
      ) u_line_delay (
         .clk  (clk),
         .rst  (rst),
         .en   (bus.pixel_valid),
         .din  (tap[k-1]),
         .dout (tap[k])
      );
   end

   // Raster position counters; they advance only on accepted pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else if (bus.pixel_valid) begin
         if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   // Window shift register: rows shift left, right column loads oldest tap on top.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < FILTERHEIGHT; r++) begin
            for (int c = 0; c < FILTERWIDTH; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (bus.pixel_valid) begin
         for (int r = 0; r < FILTERHEIGHT; r++) begin
            for (int c = 0; c < FILTERWIDTH - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][FILTERWIDTH-1] <= tap[FILTERHEIGHT-1-r];
         end
      end
   end

   // Registered window_valid / frame_done pulses; a stall clears both.
   always_ff @(posedge clk) begin
      if (rst) begin
         window_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         window_valid_q <= bus.pixel_valid && win_complete;
         frame_done_q   <= bus.pixel_valid && last_row && last_col;
      end
   end

   // Pack the window into the kernel's slot layout.
   always_comb begin
      window_flat = '0;
      for (int r = 0; r < FILTERHEIGHT; r++) begin
         for (int c = 0; c < FILTERWIDTH; c++) begin
            window_flat[slot_idx(r, c, FILTERWIDTH)*N +: N] = win_q[r][c];
         end
      end
   end

   assign bus.window_out   = window_flat;
   assign bus.window_valid = window_valid_q;
   assign bus.frame_done   = frame_done_q;

endmodule
